// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: shared widths and types for the MEM/WB writeback and register-file slice.
package rv_pipe_pkg;
    localparam int XLEN_C  = 32;
    localparam int AW_C    = 5;
    localparam int NREGS_C = 32;
    typedef logic [AW_C-1:0]   reg_addr_t;
    typedef logic [XLEN_C-1:0] xword_t;
    localparam reg_addr_t REG_X0 = 5'd0;
endpackage

// File: rtl/load_scoreboard.sv
// load_scoreboard: per-register pending-load bits and load-use stall compare.
// WB_BYPASS_EN: a bit cleared this cycle no longer contributes to the stall.
module load_scoreboard
    import rv_pipe_pkg::*;
#(
    parameter int NREGS = NREGS_C,
    parameter int AW    = AW_C
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue,
    input  logic [AW-1:0]    set_idx,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_idx,
    input  logic [AW-1:0]    rs1,
    input  logic [AW-1:0]    rs2,
    output logic [NREGS-1:0] busy,
    output logic             stall
);
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;
    logic [NREGS-1:0] view;
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue && !stall && set_idx != '0) set_mask[set_idx] = 1'b1;
        if (clr_en && clr_idx != '0) clr_mask[clr_idx] = 1'b1;
`ifdef WB_BYPASS_EN
        view = busy & ~clr_mask;
`else
        view = busy;
`endif
        stall = (view[rs1] && rs1 != '0) || (view[rs2] && rs2 != '0);
    end
    // set applied after clear so a newer load to the same register stays pending
    always_ff @(posedge clk or posedge rst)
        if (rst) busy <= '0;
        else     busy <= (busy & ~clr_mask) | set_mask;
endmodule

// File: rtl/wb_regfile_scoreboard.sv
// wb_regfile_scoreboard: MEM/WB consumer committing to a 32x32 register file with load scoreboard.
// WB_BYPASS_EN: reads matching a same-cycle writeback return wb_data_i.
module wb_regfile_scoreboard
    import rv_pipe_pkg::*;
#(
    parameter int XLEN  = XLEN_C,
    parameter int NREGS = NREGS_C,
    parameter int AW    = AW_C
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [XLEN-1:0]  wb_data_i,
    input  logic             wb_reg_w_i,
    input  logic [AW-1:0]    wb_reg_d_i,
    input  logic             wb_mem_r_i,
    input  logic [AW-1:0]    rs1_addr_i,
    input  logic [AW-1:0]    rs2_addr_i,
    output logic [XLEN-1:0]  rs1_data_o,
    output logic [XLEN-1:0]  rs2_data_o,
    input  logic             ld_issue_i,
    input  logic [AW-1:0]    ld_rd_i,
    output logic             ld_stall_o,
    output logic [NREGS-1:0] busy_o
);
    logic [XLEN-1:0] regs [NREGS];
    logic            wb_valid;
    assign wb_valid = wb_reg_w_i && wb_reg_d_i != AW'(REG_X0);
    always_ff @(posedge clk_i or posedge reset_i)
        if (reset_i) for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        else if (wb_valid) regs[wb_reg_d_i] <= wb_data_i;
    always_comb begin
`ifdef WB_BYPASS_EN
        rs1_data_o = (reset_i || rs1_addr_i == '0) ? '0 :
                     (wb_valid && wb_reg_d_i == rs1_addr_i) ? wb_data_i : regs[rs1_addr_i];
        rs2_data_o = (reset_i || rs2_addr_i == '0) ? '0 :
                     (wb_valid && wb_reg_d_i == rs2_addr_i) ? wb_data_i : regs[rs2_addr_i];
`else
        rs1_data_o = (reset_i || rs1_addr_i == '0) ? '0 : regs[rs1_addr_i];
        rs2_data_o = (reset_i || rs2_addr_i == '0) ? '0 : regs[rs2_addr_i];
`endif
    end
    load_scoreboard #(.NREGS(NREGS), .AW(AW)) u_sb (
        .clk     (clk_i),
        .rst     (reset_i),
        .issue   (ld_issue_i),
        .set_idx (ld_rd_i),
        .clr_en  (wb_reg_w_i && wb_mem_r_i),
        .clr_idx (wb_reg_d_i),
        .rs1     (rs1_addr_i),
        .rs2     (rs2_addr_i),
        .busy    (busy_o),
        .stall   (ld_stall_o)
    );
endmodule
